decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 3, select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 4, cycles each output stays active in scan mode; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  enable; 0 forces outputs inactive and freezes all state.
REQ-006 mode  input  1  0 = DIRECT (decode A), 1 = SCAN (auto-step through outputs).
REQ-007 A  input  N  select value, used in DIRECT and as the scan start point.
REQ-008 Y  output  2**N  registered one-hot decode output.
REQ-009 idx  output  N  registered index of the currently active Y bit.
REQ-010 wrap  output  1  one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-011 Y, idx and wrap shall all be registers; no combinational path from any input to any output.
REQ-012 DIRECT, en=1: Y shall equal one-hot(A) and idx shall equal A one cycle after A is sampled (latency 1).
REQ-013 Y shall always be all-zero or exactly one-hot; Y[idx] shall be 1 whenever Y is nonzero.
REQ-014 States: IDLE (en=0 or after reset), DIRECT, SCAN; the state follows en and mode each cycle.
REQ-015 Entry into SCAN (previous state not SCAN, mode=1, en=1) shall load idx from A, clear the dwell counter and assert Y=one-hot(A) on the next edge.
REQ-016 In SCAN the dwell counter shall count 0..DWELL-1; at DWELL-1 it shall clear and idx shall increment by 1 on the same edge.
REQ-017 Increment from 2**N-1 shall wrap idx to 0 and assert wrap for exactly that one cycle; wrap shall be 0 in every other cycle.
REQ-018 DWELL=1: idx shall advance every cycle in SCAN.
REQ-019 In SCAN, A shall be ignored after the entry cycle.
REQ-020 en=0: Y shall go to zero on the next edge, wrap shall be 0, and idx and the dwell counter shall hold.
REQ-021 en 0->1 with mode=1 and previous state SCAN (paused): scanning shall resume from the held idx and dwell count, with no reload from A.
REQ-022 SCAN->DIRECT (mode 1->0): the next edge shall show one-hot(A), and the dwell counter shall clear.
REQ-023 en falling and mode changing in the same cycle: en shall take priority; the state goes to IDLE with the pause rules of REQ-020.

Reset
REQ-024 rst=1 at a clock edge shall set Y=0, idx=0, wrap=0, dwell counter=0 and state=IDLE, overriding every other input.
REQ-025 rst asserted mid-scan shall abandon the scan; after rst deasserts, SCAN with mode=1 and en=1 shall re-enter via REQ-015.

Structure
REQ-026 Package decoder_scan_pkg shall hold the state enum (IDLE, DIRECT, SCAN) and the mode encoding constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-027 Sub-module dwell_counter shall hold the dwell counter: parameter DWELL; inputs clr and inc; output tick.
REQ-028 dwell_counter shall use a counter of width $clog2(DWELL+1).
REQ-029 Decode shall use a shift of 1 by idx, with no hand-written case table.

Verification
REQ-030 N=3, DIRECT, en=1, A swept 0..7: one cycle later Y=00000001..10000000 and idx=A at each step.
REQ-031 N=3, DWELL=4, SCAN entered with A=6: Y=01000000 for 4 cycles, then 10000000 for 4 cycles, then 00000001 with wrap=1 for exactly one cycle.
REQ-032 Mid-scan at idx=2, en=0 for 5 cycles: Y=0 and idx=2 held; after en=1, idx=2 finishes its remaining dwell cycles, then idx=3.
REQ-033 rst=1 asserted at idx=5 in SCAN: next edge gives Y=0, idx=0, wrap=0; re-entry with A=1 gives Y=00000010.
REQ-034 N=2, DWELL=1, SCAN from A=0: Y cycles 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with wrap on the cycle idx returns to 0.
REQ-035 Every scenario: assertions shall check Y one-hot-or-zero (REQ-013) and wrap never high two cycles in a row.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared state and mode encodings for the decoder_scan block.
package decoder_scan_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Counts 0..DWELL-1 while inc is high; tick flags the last count so the caller
// can advance on the same edge the counter clears.
module dwell_counter
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tick
);

    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder: DIRECT decodes A, SCAN steps through every output,
// holding each for DWELL cycles and pulsing wrap when the index rolls over.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    A,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int unsigned W = 2 ** N;
    localparam logic [W-1:0] ONE = W'(1);

    logic [1:0]   state_q, state_d;
    logic         paused_q, paused_d;
    logic [N-1:0] idx_q, idx_d;
    logic [W-1:0] y_q, y_d;
    logic         wrap_q, wrap_d;
    logic         cnt_clr, cnt_inc, tick;
    logic         resume;

    // A scan interrupted by en=0 leaves state IDLE; paused_q remembers it so the
    // scan picks up where it stopped instead of reloading from A.
    assign resume = (state_q == SCAN) || paused_q;

    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        idx_d    = idx_q;
        y_d      = y_q;
        wrap_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            y_d     = '0;
            if (state_q == SCAN) begin
                paused_d = 1'b1;
            end
        end else if (mode == MODE_DIRECT) begin
            state_d  = DIRECT;
            paused_d = 1'b0;
            idx_d    = A;
            y_d      = ONE << A;
            cnt_clr  = 1'b1;
        end else if (!resume) begin
            state_d = SCAN;
            idx_d   = A;
            y_d     = ONE << A;
            cnt_clr = 1'b1;
        end else begin
            state_d  = SCAN;
            paused_d = 1'b0;
            cnt_inc  = 1'b1;
            if (tick) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = &idx_q;
            end
            y_d = ONE << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            paused_q <= 1'b0;
            idx_q    <= '0;
            y_q      <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            idx_q    <= idx_d;
            y_q      <= y_d;
            wrap_q   <= wrap_d;
        end
    end

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tick(tick)
    );

    assign Y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: an N=3/DWELL=4 instance and an N=2/DWELL=1 instance.
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, en0 = 1'b0, mode0 = 1'b0;
    logic [2:0] a0 = '0;
    logic [7:0] y0;
    logic [2:0] idx0;
    logic       wrap0;

    logic       rst1 = 1'b1, en1 = 1'b0, mode1 = 1'b0;
    logic [1:0] a1 = '0;
    logic [3:0] y1;
    logic [1:0] idx1;
    logic       wrap1;

    int total = 0;
    int bad   = 0;

    decoder_scan #(.N(3), .DWELL(4)) dut0 (
        .clk (clk),
        .rst (rst0),
        .en  (en0),
        .mode(mode0),
        .A   (a0),
        .Y   (y0),
        .idx (idx0),
        .wrap(wrap0)
    );

    decoder_scan #(.N(2), .DWELL(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .en  (en1),
        .mode(mode1),
        .A   (a1),
        .Y   (y1),
        .idx (idx1),
        .wrap(wrap1)
    );

    logic [7:0] direct_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] scan_y_exp [10] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80,
                                    8'h01, 8'h01};
    logic [2:0] scan_i_exp [10] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};
    logic       scan_w_exp [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] d1_y_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic       d1_w_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Invariants on both instances every cycle.
    logic prev_wrap0 = 1'b0, prev_wrap1 = 1'b0;
    always @(negedge clk) begin
        total = total + 1;
        if (((y0 & (y0 - 8'd1)) !== 8'd0) || (y0 !== 8'd0 && y0[idx0] !== 1'b1)) begin
            bad = bad + 1;
            $display("FAIL onehot0 dut0: Y=%b idx=%0d", y0, idx0);
        end
        total = total + 1;
        if (((y1 & (y1 - 4'd1)) !== 4'd0) || (y1 !== 4'd0 && y1[idx1] !== 1'b1)) begin
            bad = bad + 1;
            $display("FAIL onehot1 dut1: Y=%b idx=%0d", y1, idx1);
        end
        total = total + 1;
        if ((prev_wrap0 && wrap0) || (prev_wrap1 && wrap1)) begin
            bad = bad + 1;
            $display("FAIL wrap_twice: wrap0=%b wrap1=%b required single-cycle", wrap0, wrap1);
        end
        prev_wrap0 = wrap0;
        prev_wrap1 = wrap1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; en0 = 1'b1; mode0 = 1'b1; a0 = 3'd5;
        step();
        step();
        total = total + 3;
        if (y0 !== 8'd0) begin bad = bad + 1; $display("FAIL reset_y: got %b want 0", y0); end
        if (idx0 !== 3'd0) begin bad = bad + 1; $display("FAIL reset_idx: got %0d want 0", idx0); end
        if (wrap0 !== 1'b0) begin bad = bad + 1; $display("FAIL reset_wrap: got %b want 0", wrap0); end
        rst0 = 1'b0;
    endtask

    task automatic test_direct();
        en0 = 1'b1; mode0 = 1'b0;
        for (int a = 0; a < 8; a++) begin
            a0 = 3'(a);
            step();
            total = total + 2;
            if (y0 !== direct_exp[a]) begin
                bad = bad + 1;
                $display("FAIL direct_y A=%0d: got %b want %b", a, y0, direct_exp[a]);
            end
            if (idx0 !== 3'(a)) begin
                bad = bad + 1;
                $display("FAIL direct_idx A=%0d: got %0d want %0d", a, idx0, a);
            end
        end
    endtask

    task automatic test_scan_wrap();
        mode0 = 1'b1; a0 = 3'd6;
        for (int i = 0; i < 10; i++) begin
            step();
            a0 = 3'd0;
            total = total + 3;
            if (y0 !== scan_y_exp[i]) begin
                bad = bad + 1;
                $display("FAIL scan_y c%0d: got %b want %b", i, y0, scan_y_exp[i]);
            end
            if (idx0 !== scan_i_exp[i]) begin
                bad = bad + 1;
                $display("FAIL scan_idx c%0d: got %0d want %0d", i, idx0, scan_i_exp[i]);
            end
            if (wrap0 !== scan_w_exp[i]) begin
                bad = bad + 1;
                $display("FAIL scan_wrap c%0d: got %b want %b", i, wrap0, scan_w_exp[i]);
            end
        end
    endtask

    task automatic test_pause();
        mode0 = 1'b0; a0 = 3'd0;
        step();
        mode0 = 1'b1; a0 = 3'd2;
        step();
        step();
        // en drops together with a mode change; en must win.
        en0 = 1'b0; mode0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total = total + 3;
            if (y0 !== 8'd0) begin bad = bad + 1; $display("FAIL pause_y c%0d: got %b want 0", i, y0); end
            if (idx0 !== 3'd2) begin bad = bad + 1; $display("FAIL pause_idx c%0d: got %0d want 2", i, idx0); end
            if (wrap0 !== 1'b0) begin bad = bad + 1; $display("FAIL pause_wrap c%0d: got %b want 0", i, wrap0); end
        end
        en0 = 1'b1; mode0 = 1'b1; a0 = 3'd5;
        step();
        total = total + 2;
        if (y0 !== 8'h04) begin bad = bad + 1; $display("FAIL resume_y0: got %b want 00000100", y0); end
        if (idx0 !== 3'd2) begin bad = bad + 1; $display("FAIL resume_idx0: got %0d want 2", idx0); end
        step();
        total = total + 1;
        if (y0 !== 8'h04) begin bad = bad + 1; $display("FAIL resume_y1: got %b want 00000100", y0); end
        step();
        total = total + 2;
        if (y0 !== 8'h08) begin bad = bad + 1; $display("FAIL resume_y2: got %b want 00001000", y0); end
        if (idx0 !== 3'd3) begin bad = bad + 1; $display("FAIL resume_idx2: got %0d want 3", idx0); end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < 8; i++) step();
        total = total + 1;
        if (idx0 !== 3'd5) begin bad = bad + 1; $display("FAIL midscan_idx: got %0d want 5", idx0); end
        rst0 = 1'b1; a0 = 3'd1;
        step();
        total = total + 3;
        if (y0 !== 8'd0) begin bad = bad + 1; $display("FAIL midrst_y: got %b want 0", y0); end
        if (idx0 !== 3'd0) begin bad = bad + 1; $display("FAIL midrst_idx: got %0d want 0", idx0); end
        if (wrap0 !== 1'b0) begin bad = bad + 1; $display("FAIL midrst_wrap: got %b want 0", wrap0); end
        rst0 = 1'b0;
        step();
        total = total + 2;
        if (y0 !== 8'h02) begin bad = bad + 1; $display("FAIL reentry_y: got %b want 00000010", y0); end
        if (idx0 !== 3'd1) begin bad = bad + 1; $display("FAIL reentry_idx: got %0d want 1", idx0); end
    endtask

    task automatic test_dwell_one();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0; en1 = 1'b1; mode1 = 1'b1; a1 = 2'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            total = total + 2;
            if (y1 !== d1_y_exp[i]) begin
                bad = bad + 1;
                $display("FAIL dwell1_y c%0d: got %b want %b", i, y1, d1_y_exp[i]);
            end
            if (wrap1 !== d1_w_exp[i]) begin
                bad = bad + 1;
                $display("FAIL dwell1_wrap c%0d: got %b want %b", i, wrap1, d1_w_exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_pause();
        test_reset_mid_scan();
        test_dwell_one();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
